// File: rtl/cl_muxn_reg_pkg.sv
// Shared definitions for the one-hot select control blocks: output-buffer state,
// channel slicing, the illegal-select rule and the saturating counter.
package cl_muxn_reg_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   // Channel k lives at bits [k*dw +: dw] of the flattened data bus, channel 0 at the LSBs.
   function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned dw);
      return ch * dw;
   endfunction

   // A select is illegal when no bit or more than one bit is set.
   function automatic logic sel_illegal(input logic onehot, input logic zero);
      return zero || !onehot;
   endfunction

   // Saturating increment for a counter that is w bits wide (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
      logic [31:0] max_val;
      max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (cnt >= max_val) ? max_val : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/cl_onehot_chk.sv
// Classifies a select vector as exactly-one-hot and/or all-zero.
module cl_onehot_chk #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0] i_sel,
   output logic              o_onehot,
   output logic              o_zero
);

   logic seen;
   logic multi;

   always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (i_sel[k]) begin
            if (seen) multi = 1'b1;
            seen = 1'b1;
         end
      end
      o_onehot = seen && !multi;
      o_zero   = !seen;
   end

endmodule

// File: rtl/cl_muxn_reg.sv
// N-way one-hot data selector with a single registered output beat, valid/ready
// on both sides, and sticky logging of illegal selects.
module cl_muxn_reg
   import cl_muxn_reg_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 5,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_CH-1:0]            i_sel,
   input  logic                         i_sel_vld,
   output logic                         o_sel_rdy,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_vld,
   input  logic                         i_rdy,
   output logic                         o_err,
   output logic [NUM_CH-1:0]            o_err_sel,
   output logic [ERR_CNT_W-1:0]         o_err_cnt,
   input  logic                         i_err_clr
);

   // Handshake: a select transfers on any edge where i_sel_vld && o_sel_rdy;
   // an output beat transfers on any edge where o_vld && i_rdy. Neither side
   // may withdraw or change a presented beat before it transfers.

   buf_state_t            state;
   logic                  sel_onehot;
   logic                  sel_zero;
   logic                  accept;
   logic                  legal_acc;
   logic                  illegal_acc;
   logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
   logic [DATA_WIDTH-1:0] sel_data;
   logic [31:0]           cnt_inc;

   cl_onehot_chk #(
      .NUM_CH (NUM_CH)
   ) u_onehot_chk (
      .i_sel    (i_sel),
      .o_onehot (sel_onehot),
      .o_zero   (sel_zero)
   );

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
      assign ch_data[k] = i_data[chan_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
   end

   // AND-OR mux; only meaningful when the select is one-hot.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (i_sel[k]) sel_data = sel_data | ch_data[k];
      end
   end

   assign o_vld       = (state == ST_FULL);
   assign o_sel_rdy   = !o_vld || i_rdy;
   assign accept      = i_sel_vld && o_sel_rdy;
   assign illegal_acc = accept && sel_illegal(sel_onehot, sel_zero);
   assign legal_acc   = accept && !sel_illegal(sel_onehot, sel_zero);
   assign cnt_inc     = sat_inc(32'(o_err_cnt), ERR_CNT_W);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_EMPTY;
         o_data <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (legal_acc) begin
                  state  <= ST_FULL;
                  o_data <= sel_data;
               end
            end
            ST_FULL: begin
               // A legal accept here implies i_rdy, so the old beat leaves as the new one lands.
               if (legal_acc) begin
                  o_data <= sel_data;
               end else if (i_rdy) begin
                  state <= ST_EMPTY;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_err     <= 1'b0;
         o_err_sel <= '0;
         o_err_cnt <= '0;
      end else if (illegal_acc) begin
         // A simultaneous clear loses to the new error, which then counts as the first one.
         o_err <= 1'b1;
         if (!o_err || i_err_clr) o_err_sel <= i_sel;
         if (i_err_clr) o_err_cnt <= ERR_CNT_W'(1);
         else           o_err_cnt <= cnt_inc[ERR_CNT_W-1:0];
      end else if (i_err_clr) begin
         o_err     <= 1'b0;
         o_err_sel <= '0;
         o_err_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_cl_muxn_reg.sv
// Directed bench for cl_muxn_reg: driver tasks push expected beats into a queue,
// a negedge monitor pops and compares every transferred output beat.
`timescale 1ns/1ps
module tb_cl_muxn_reg;

   localparam int NUM_CH     = 4;
   localparam int DATA_WIDTH = 5;
   localparam int ERR_CNT_W  = 8;

   logic                         i_clk;
   logic                         i_rst;
   logic [NUM_CH-1:0]            i_sel;
   logic                         i_sel_vld;
   logic                         o_sel_rdy;
   logic [NUM_CH*DATA_WIDTH-1:0] i_data;
   logic [DATA_WIDTH-1:0]        o_data;
   logic                         o_vld;
   logic                         i_rdy;
   logic                         o_err;
   logic [NUM_CH-1:0]            o_err_sel;
   logic [ERR_CNT_W-1:0]         o_err_cnt;
   logic                         i_err_clr;

   logic [DATA_WIDTH-1:0] exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic        m_vld    = 1'b0;

   localparam logic [NUM_CH*DATA_WIDTH-1:0] DATA_TBL = {5'h1F, 5'h11, 5'h0A, 5'h03};

   cl_muxn_reg #(
      .NUM_CH     (NUM_CH),
      .DATA_WIDTH (DATA_WIDTH),
      .ERR_CNT_W  (ERR_CNT_W)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sel     (i_sel),
      .i_sel_vld (i_sel_vld),
      .o_sel_rdy (o_sel_rdy),
      .i_data    (i_data),
      .o_data    (o_data),
      .o_vld     (o_vld),
      .i_rdy     (i_rdy),
      .o_err     (o_err),
      .o_err_sel (o_err_sel),
      .o_err_cnt (o_err_cnt),
      .i_err_clr (i_err_clr)
   );

   // clock / watchdog
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      else n_pass++;
   endtask

   // scoreboard monitor
   always @(negedge i_clk) begin
      logic [DATA_WIDTH-1:0] e;
      if (i_rst === 1'b0 && o_vld === 1'b1 && i_rdy === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_beat: actual=%0h required=no beat", o_data);
         end else begin
            e = exp_q.pop_front();
            if (o_data !== e) $display("FAIL beat_data: actual=%0h required=%0h", o_data, e);
            else n_pass++;
         end
      end
   end

   // driver: apply one cycle of inputs and track the expected buffer occupancy
   task automatic step(input logic [3:0] sel, input logic vld, input logic rdy,
                       input logic clr, input logic [4:0] exp_d);
      logic acc;
      logic legal;
      i_sel     = sel;
      i_sel_vld = vld;
      i_rdy     = rdy;
      i_err_clr = clr;
      acc   = vld && (!m_vld || rdy);
      legal = ($countones(sel) == 1);
      if (acc && legal) exp_q.push_back(exp_d);
      @(posedge i_clk);
      #1;
      if (acc && legal) m_vld = 1'b1;
      else if (rdy)     m_vld = 1'b0;
   endtask

   task automatic idle();
      step(4'b0000, 1'b0, 1'b1, 1'b0, 5'h00);
   endtask

   task automatic reset_cycles(input int n, input logic rdy);
      i_rst = 1'b1;
      for (int c = 0; c < n; c++) begin
         i_sel     = NUM_CH'($urandom_range(0, 15));
         i_sel_vld = 1'($urandom_range(0, 1));
         i_err_clr = 1'($urandom_range(0, 1));
         i_rdy     = rdy;
         i_data    = NUM_CH*DATA_WIDTH'($urandom);
         @(posedge i_clk);
         #1;
      end
      exp_q.delete();
      m_vld     = 1'b0;
      i_rst     = 1'b0;
      i_sel     = '0;
      i_sel_vld = 1'b0;
      i_err_clr = 1'b0;
      i_rdy     = 1'b1;
      i_data    = DATA_TBL;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_o_data"},    32'(o_data),    32'h0);
      check({tag, "_o_vld"},     32'(o_vld),     32'h0);
      check({tag, "_o_err"},     32'(o_err),     32'h0);
      check({tag, "_o_err_sel"}, 32'(o_err_sel), 32'h0);
      check({tag, "_o_err_cnt"}, 32'(o_err_cnt), 32'h0);
      check({tag, "_o_sel_rdy"}, 32'(o_sel_rdy), 32'h1);
   endtask

   initial begin
      logic [3:0] legal_sel [4];
      logic [4:0] legal_exp [4];
      logic [3:0] bad_sel   [4];
      legal_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      legal_exp = '{5'h03, 5'h0A, 5'h11, 5'h1F};
      bad_sel   = '{4'b0110, 4'b1001, 4'b1111, 4'b0000};

      // reset with random inputs
      reset_cycles(2, 1'($urandom_range(0, 1)));
      check_all_zero("reset");

      // legal stream, full throughput
      for (int i = 0; i < 4; i++) begin
         step(legal_sel[i], 1'b1, 1'b1, 1'b0, legal_exp[i]);
         check("stream_vld", 32'(o_vld), 32'h1);
      end
      idle();
      check("stream_drained", 32'(o_vld), 32'h0);

      // backpressure with data changing on the bus while stalled
      step(4'b0100, 1'b1, 1'b1, 1'b0, 5'h11);
      for (int i = 0; i < 3; i++) begin
         i_data = NUM_CH*DATA_WIDTH'($urandom);
         step(4'b0100, 1'b1, 1'b0, 1'b0, 5'h00);
         check("stall_data", 32'(o_data), 32'h11);
         check("stall_vld", 32'(o_vld), 32'h1);
         check("stall_sel_rdy", 32'(o_sel_rdy), 32'h0);
      end
      i_data = DATA_TBL;
      step(4'b0001, 1'b1, 1'b1, 1'b0, 5'h03);
      check("release_data", 32'(o_data), 32'h03);
      idle();

      // illegal selects produce no beat but are logged
      step(4'b0000, 1'b1, 1'b1, 1'b0, 5'h00);
      step(4'b0110, 1'b1, 1'b1, 1'b0, 5'h00);
      step(4'b1001, 1'b1, 1'b1, 1'b0, 5'h00);
      check("illegal_vld", 32'(o_vld), 32'h0);
      check("illegal_err", 32'(o_err), 32'h1);
      check("illegal_err_sel", 32'(o_err_sel), 32'h0);
      check("illegal_err_cnt", 32'(o_err_cnt), 32'h3);
      step(4'b0010, 1'b1, 1'b1, 1'b0, 5'h0A);
      check("after_illegal_data", 32'(o_data), 32'h0A);
      idle();

      // clear colliding with a new error, then a lone clear
      step(4'b1100, 1'b1, 1'b1, 1'b1, 5'h00);
      check("collide_err", 32'(o_err), 32'h1);
      check("collide_err_sel", 32'(o_err_sel), 32'hC);
      check("collide_err_cnt", 32'(o_err_cnt), 32'h1);
      step(4'b0000, 1'b0, 1'b1, 1'b1, 5'h00);
      check("clear_err", 32'(o_err), 32'h0);
      check("clear_err_sel", 32'(o_err_sel), 32'h0);
      check("clear_err_cnt", 32'(o_err_cnt), 32'h0);

      // counter saturation
      for (int i = 0; i < 260; i++) begin
         step(bad_sel[i % 4], 1'b1, 1'b1, 1'b0, 5'h00);
         if (i == 253) check("sat_cnt_254", 32'(o_err_cnt), 32'hFE);
      end
      check("sat_cnt", 32'(o_err_cnt), 32'hFF);
      check("sat_err_sel", 32'(o_err_sel), 32'h6);

      // reset while a beat is stalled
      step(4'b1000, 1'b1, 1'b1, 1'b0, 5'h1F);
      step(4'b0000, 1'b0, 1'b0, 1'b0, 5'h00);
      check("pre_rst_vld", 32'(o_vld), 32'h1);
      check("pre_rst_data", 32'(o_data), 32'h1F);
      reset_cycles(1, 1'b0);
      check_all_zero("mid_rst");

      idle();
      idle();
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cl_muxn_reg.md
Name: cl_muxn_reg

Overview:
- N-way, one-hot-select data selector with a registered output stage and a valid/ready handshake on both sides.
- Generalises the 2-way one-hot mux in the control library to NUM_CH channels.
- Adds detection and logging of illegal (zero or multi-hot) selects, which are dropped rather than passed on as zero data.
- Sits between channel sources and a single downstream consumer in the control path.

Parameters:
- NUM_CH, 4, number of input channels; must be >= 2.
- DATA_WIDTH, 5, width of each channel's data.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_sel  input  NUM_CH  one-hot channel select; bit k selects channel k.
- i_sel_vld  input  1  i_sel/i_data valid this cycle.
- o_sel_rdy  output  1  block can accept a select this cycle.
- i_data  input  NUM_CH*DATA_WIDTH  flattened channel data; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_data  output  DATA_WIDTH  registered selected data.
- o_vld  output  1  o_data valid.
- i_rdy  input  1  downstream accepts o_data.
- o_err  output  1  sticky illegal-select flag.
- o_err_sel  output  NUM_CH  i_sel pattern of the first illegal select since the last clear.
- o_err_cnt  output  ERR_CNT_W  saturating count of illegal selects.
- i_err_clr  input  1  clears o_err, o_err_sel and o_err_cnt.

Behaviour:
- Reset: with i_rst=1 at a rising edge, all outputs go to 0 (o_data, o_vld, o_err, o_err_sel, o_err_cnt). i_rst has priority over all other inputs.
- o_sel_rdy is combinational: !o_vld || i_rdy.
- Accept condition: i_sel_vld && o_sel_rdy.
- Legal accept (i_sel has exactly one bit set):
  - o_data <= the selected channel's data; o_vld <= 1 next cycle.
  - Latency is 1 cycle; throughput is 1 beat per cycle with i_rdy held high.
- Illegal accept (i_sel == 0 or popcount > 1):
  - The handshake completes but no output beat is produced.
  - o_vld <= 0 if i_rdy, else o_vld and o_data hold.
  - o_err <= 1.
  - o_err_sel <= i_sel only if o_err was 0; the first offender is kept.
  - o_err_cnt increments and saturates at all-ones.
- No accept: if o_vld && i_rdy then o_vld <= 0. While o_vld && !i_rdy, o_data and o_vld hold stable.
- i_err_clr alone clears o_err, o_err_sel and o_err_cnt to 0.
- i_err_clr in the same cycle as an illegal accept: the new error wins. Result is o_err=1, o_err_sel=new pattern, o_err_cnt=1.
- i_err_clr has no effect on the data path.
- Data inputs are sampled only on an accept. Changes to i_data on non-selected channels, or in non-accept cycles, never affect o_data.
- Only one state machine is implied: a single output register, EMPTY (o_vld=0) / FULL (o_vld=1).
  - EMPTY->FULL on legal accept.
  - FULL->EMPTY on i_rdy without legal accept.
  - FULL->FULL on i_rdy with legal accept, or on !i_rdy.

Decomposition:
- Shared control package holds:
  - the channel-slice width rule (DATA_WIDTH per channel, LSB channel 0);
  - the illegal-select definition (zero or multi-hot);
  - the saturating-counter convention.
- One natural sub-module, cl_onehot_chk, parametrised by NUM_CH:
  - outputs o_onehot (exactly one bit set) and o_zero;
  - reused by other one-hot-select blocks in the control library.

Test Plan:
- Reset: drive i_rst=1 for 2 cycles with random inputs -> all outputs 0, o_sel_rdy=1 after reset.
- Legal stream (NUM_CH=4, DATA_WIDTH=5): ch0..ch3 = 5'h03, 5'h0A, 5'h11, 5'h1F; i_sel = 0001, 0010, 0100, 1000 on consecutive cycles with i_rdy=1 -> o_data = 03, 0A, 11, 1F one cycle later each, o_vld=1 continuously.
- Backpressure: legal i_sel=0100 accepted, then i_rdy=0 for 3 cycles -> o_data=5'h11 and o_vld held, o_sel_rdy=0; on i_rdy=1 the next beat is accepted the same cycle.
- Illegal selects: i_sel=0000, then 0110, then 1001 -> no o_vld pulse, o_err=1, o_err_sel=0000, o_err_cnt=3. Then a legal 0010 -> o_data=5'h0A.
- Clear collision: i_err_clr=1 in the same cycle as illegal i_sel=1100 -> o_err=1, o_err_sel=1100, o_err_cnt=1. A lone clear afterwards -> all three are 0.
- Saturation and mid-operation reset:
  - 260 illegal selects with ERR_CNT_W=8 -> o_err_cnt=8'hFF.
  - Then i_rst=1 while o_vld=1 and i_rdy=0 -> next cycle all outputs 0.
